// File: rtl/vj_sched_pkg.sv
// vj_sched_pkg: scheduler state, descriptor type and pyramid geometry/mapping tables.
// Default vj_weights table macros (32x32 image, 4 levels) apply unless already defined.
`ifndef PYRAMID_LEVELS
`define PYRAMID_LEVELS 4
`define LAPTOP_WIDTH 32
`define LAPTOP_HEIGHT 32
`define PYRAMID_WIDTHS '{32, 28, 25, 20}
`define PYRAMID_HEIGHTS '{32, 28, 25, 20}
`define PYRAMID_X_MAPPINGS '{ \
    '{0,1,2,4,5,6,7,8,9,10,12,13,14,15,16,17,18,20,21,22,23,24,25,26,28,29,30,31,0,0,0,0}, \
    '{0,1,3,4,5,7,8,9,10,12,13,14,16,17,18,19,21,22,23,24,26,27,28,30,31,0,0,0,0,0,0,0}, \
    '{0,2,4,5,7,8,10,12,13,15,16,18,20,21,23,24,26,28,29,31,0,0,0,0,0,0,0,0,0,0,0,0}}
`define PYRAMID_Y_MAPPINGS `PYRAMID_X_MAPPINGS
`endif

package vj_sched_pkg;
    localparam int NL = `PYRAMID_LEVELS;
    localparam int LW = $clog2(NL);
    localparam int CW = $clog2(`LAPTOP_WIDTH);
    localparam int widths [NL] = `PYRAMID_WIDTHS;
    localparam int heights [NL] = `PYRAMID_HEIGHTS;
    localparam int x_map [NL-1][`LAPTOP_WIDTH] = `PYRAMID_X_MAPPINGS;
    localparam int y_map [NL-1][`LAPTOP_HEIGHT] = `PYRAMID_Y_MAPPINGS;
    typedef enum logic [2:0] {IDLE, LOAD, SCAN, NEXT, DONE} state_t;
    typedef struct packed {
        logic [LW-1:0] level;
        logic [CW-1:0] x;
        logic [CW-1:0] y;
        logic [CW-1:0] src_x;
        logic [CW-1:0] src_y;
    } win_desc_t;
endpackage

// File: rtl/pyramid_coord_map.sv
// pyramid_coord_map: combinational downscaled (level,x,y) to full-size (src_x,src_y) lookup.
module pyramid_coord_map
    import vj_sched_pkg::*;
(
    input  logic [LW-1:0] level,
    input  logic [CW-1:0] x,
    input  logic [CW-1:0] y,
    output logic [CW-1:0] src_x,
    output logic [CW-1:0] src_y
);
    logic [LW-1:0] row;
    // level 0 is the full-size image, so tables start at level 1
    always_comb begin
        row = (level == '0) ? '0 : level - LW'(1);
        src_x = (level == '0) ? x : CW'(x_map[row][x]);
        src_y = (level == '0) ? y : CW'(y_map[row][y]);
    end
endmodule

// File: rtl/pyramid_scan_scheduler.sv
// pyramid_scan_scheduler: walks pyramid levels and raster-scans window origins for the classifier.
// Optional PYRAMID_LEVEL_MASK_EN adds a level_mask port latched at start to skip levels.
module pyramid_scan_scheduler
    import vj_sched_pkg::*;
#(
    parameter int WIN_SIZE = 24,
    parameter int STEP = 1
) (
    input  logic          clock,
    input  logic          reset,
    input  logic          start,
`ifdef PYRAMID_LEVEL_MASK_EN
    input  logic [NL-1:0] level_mask,
`endif
    output logic          busy,
    output logic          done,
    output logic          win_valid,
    input  logic          win_ready,
    output logic [LW-1:0] win_level,
    output logic [CW-1:0] win_x,
    output logic [CW-1:0] win_y,
    output logic [CW-1:0] src_x,
    output logic [CW-1:0] src_y
);
    localparam logic [CW:0] WS = (CW+1)'(WIN_SIZE);
    localparam logic [CW:0] SP = (CW+1)'(STEP);

    state_t state;
    win_desc_t desc;
    logic [LW-1:0] lvl;
    logic [CW:0] w, h;
    logic x_adv, y_adv, skip, lvl_on;
    logic [CW-1:0] nx, ny, mx, my, map_x, map_y;

`ifdef PYRAMID_LEVEL_MASK_EN
    logic [NL-1:0] mask_q;
    assign lvl_on = mask_q[lvl];
`else
    assign lvl_on = 1'b1;
`endif

    // w,h >= WIN_SIZE whenever SCAN is active, so the subtractions cannot wrap
    always_comb begin
        x_adv = ({1'b0, desc.x} + SP) <= (w - WS);
        y_adv = ({1'b0, desc.y} + SP) <= (h - WS);
        nx = x_adv ? desc.x + CW'(STEP) : '0;
        ny = (!x_adv && y_adv) ? desc.y + CW'(STEP) : desc.y;
        mx = (state == LOAD) ? '0 : nx;
        my = (state == LOAD) ? '0 : ny;
        skip = !lvl_on || widths[lvl] < WIN_SIZE || heights[lvl] < WIN_SIZE;
    end

    pyramid_coord_map u_map (
        .level(lvl),
        .x(mx),
        .y(my),
        .src_x(map_x),
        .src_y(map_y)
    );

    always_ff @(posedge clock) begin
        if (reset) begin
            state <= IDLE;
            busy <= 1'b0;
            done <= 1'b0;
            win_valid <= 1'b0;
            desc <= '0;
            lvl <= '0;
            w <= '0;
            h <= '0;
`ifdef PYRAMID_LEVEL_MASK_EN
            mask_q <= '0;
`endif
        end else begin
            case (state)
                IDLE: if (start) begin
                    state <= LOAD;
                    busy <= 1'b1;
                    lvl <= '0;
`ifdef PYRAMID_LEVEL_MASK_EN
                    mask_q <= level_mask;
`endif
                end
                LOAD: begin
                    w <= (CW+1)'(widths[lvl]);
                    h <= (CW+1)'(heights[lvl]);
                    if (skip) state <= NEXT;
                    else begin
                        desc <= '{level: lvl, x: '0, y: '0, src_x: map_x, src_y: map_y};
                        win_valid <= 1'b1;
                        state <= SCAN;
                    end
                end
                SCAN: if (win_ready) begin
                    if (x_adv || y_adv) begin
                        desc.x <= nx;
                        desc.y <= ny;
                        desc.src_x <= map_x;
                        desc.src_y <= map_y;
                    end else begin
                        win_valid <= 1'b0;
                        state <= NEXT;
                    end
                end
                NEXT: if (lvl == LW'(NL - 1)) begin
                    done <= 1'b1;
                    state <= DONE;
                end else begin
                    lvl <= lvl + LW'(1);
                    state <= LOAD;
                end
                DONE: begin
                    done <= 1'b0;
                    busy <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign win_level = desc.level;
    assign win_x = desc.x;
    assign win_y = desc.y;
    assign src_x = desc.src_x;
    assign src_y = desc.src_y;
endmodule

// File: tb/tb_pyramid_scan_scheduler.sv
// tb_pyramid_scan_scheduler: directed checks of scan order, mapping, stalls, restarts and reset abort.
module tb_pyramid_scan_scheduler;
    import vj_sched_pkg::*;

    typedef logic [LW+4*CW-1:0] d_t;

    localparam int tw [NL] = `PYRAMID_WIDTHS;
    localparam int th [NL] = `PYRAMID_HEIGHTS;
    localparam int tx [NL-1][`LAPTOP_WIDTH] = `PYRAMID_X_MAPPINGS;
    localparam int ty [NL-1][`LAPTOP_HEIGHT] = `PYRAMID_Y_MAPPINGS;

    logic clock = 1'b0, reset = 1'b1, start = 1'b0, win_ready = 1'b0;
    logic [NL-1:0] level_mask = '1;
    logic busy, done, win_valid;
    logic [LW-1:0] win_level;
    logic [CW-1:0] win_x, win_y, src_x, src_y;

    int total = 0, bad = 0, exp_lat = 2;
    d_t exp_q[$];

    always #5 clock = ~clock;

    pyramid_scan_scheduler dut (
        .clock(clock),
        .reset(reset),
        .start(start),
`ifdef PYRAMID_LEVEL_MASK_EN
        .level_mask(level_mask),
`endif
        .busy(busy),
        .done(done),
        .win_valid(win_valid),
        .win_ready(win_ready),
        .win_level(win_level),
        .win_x(win_x),
        .win_y(win_y),
        .src_x(src_x),
        .src_y(src_y)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, want);
        end
    endtask

    function automatic d_t cur();
        return {win_level, win_x, win_y, src_x, src_y};
    endfunction

    // expected window order; done trails the last handshake by NEXT plus LOAD/NEXT per trailing skipped level
    task automatic build(input logic [NL-1:0] m);
        int last;
        last = -1;
        exp_q.delete();
        for (int l = 0; l < NL; l++)
            if (m[l] && tw[l] >= 24 && th[l] >= 24) begin
                last = l;
                for (int y = 0; y <= th[l] - 24; y++)
                    for (int x = 0; x <= tw[l] - 24; x++)
                        exp_q.push_back({LW'(l), CW'(x), CW'(y),
                                         CW'(l == 0 ? x : tx[l-1][x]), CW'(l == 0 ? y : ty[l-1][y])});
            end
        exp_lat = 2 + 2 * (NL - 1 - last);
    endtask

    task automatic scan(input bit rnd, input bit poke, input bit flip, input int abort_lvl);
        int idx, last_hs, dones, done_cyc;
        bit stall, aborted;
        idx = 0; last_hs = -100; dones = 0; done_cyc = -1; stall = 0; aborted = 0;
        start = 1'b1;
        @(negedge clock);
        start = 1'b0;
        chk("busy_t1", busy, 1);
        chk("valid_t1", win_valid, 0);
        @(negedge clock);
        chk("valid_t2", win_valid, 1);
        chk("first_desc", cur(), 0);
        for (int c = 0; c < 4000 && dones == 0; c++) begin
            if (stall) chk("hold_valid", win_valid, 1);
            chk("busy", busy, 1);
            if (win_valid) chk("desc", cur(), idx < exp_q.size() ? exp_q[idx] : '1);
            if (win_valid && win_level == 1 && win_x == 5 && win_y == 3) begin
                chk("map_x", src_x, 6);
                chk("map_y", src_y, 4);
            end
            if (done) begin
                dones++;
                done_cyc = c;
            end
            if (abort_lvl >= 0 && win_valid && int'(win_level) == abort_lvl) begin
                aborted = 1;
                break;
            end
            start = poke && (idx == 10 || done);
            if (flip && idx == 5) level_mask = 4'b1011;
            win_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            stall = win_valid && !win_ready;
            if (win_valid && win_ready) begin
                idx++;
                last_hs = c;
            end
            @(negedge clock);
        end
        start = 1'b0;
        if (aborted) begin
            reset = 1'b1;
            @(negedge clock);
            reset = 1'b0;
            chk("rst_outs", {busy, done, win_valid, win_level, win_x, win_y, src_x, src_y}, 0);
            repeat (3) begin
                @(negedge clock);
                chk("rst_idle", {busy, done, win_valid}, 0);
            end
            return;
        end
        chk("done_seen", dones, 1);
        chk("done_lat", done_cyc - last_hs, exp_lat);
        chk("count", idx, exp_q.size());
        chk("busy_end", busy, 0);
        repeat (4) begin
            @(negedge clock);
            chk("quiet", {busy, done, win_valid}, 0);
        end
    endtask

    initial begin
        repeat (3) @(negedge clock);
        chk("rst_state", {busy, done, win_valid, win_level, win_x, win_y, src_x, src_y}, 0);
        reset = 1'b0;
        win_ready = 1'b1;
        @(negedge clock);
        chk("idle", {busy, win_valid}, 0);
        build(level_mask);
        scan(0, 0, 0, -1);
        scan(1, 0, 0, -1);
        scan(0, 1, 0, -1);
        scan(0, 0, 0, 2);
        scan(0, 0, 0, -1);
`ifdef PYRAMID_LEVEL_MASK_EN
        level_mask = 4'b0101;
        build(4'b0101);
        scan(0, 0, 1, -1);
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
